multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle control FSM for the RV32I core datapath. It sequences fetch, decode, execute, memory and write-back for one instruction at a time. It drives the datapath's mux selects and write strobes, and handshakes with the unified instruction/data memory port. It also counts retired instructions and halts permanently on an unsupported opcode.

## Interface
- `RETIRE_W`, default 32: width of the retired-instruction counter.

- `clk`  in  1  core clock; all state changes on rising edge.
- `rstn`  in  1  reset; asynchronous, active-low.
- `instr`  in  32  instruction register contents; valid from DECODE onward.
- `br_taken`  in  1  branch comparator result from the ALU; valid in EXEC.
- `mem_ready`  in  1  memory completion for the current `mem_req`.
- `ir_we`  out  1  latch memory read data into the instruction register.
- `pc_we`  out  1  PC write enable.
- `pc_sel`  out  2  next PC select:
  - 0: pc+4
  - 1: pc+imm (branch-target adder)
  - 2: (alu_result & ~1)
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  store strobe; qualified by `mem_req`.
- `mem_addr_sel`  out  1  memory address select: 0 = PC, 1 = ALU result.
- `alu_a_sel`  out  1  ALU operand A select: 0 = rs1, 1 = PC.
- `alu_b_sel`  out  1  ALU operand B select: 0 = rs2, 1 = imm.
- `reg_we`  out  1  register-file write enable.
- `wb_sel`  out  2  write-back source: 0 = ALU, 1 = memory data, 2 = pc+4, 3 = imm.
- `state`  out  3  current state encoding, for debug.
- `halted`  out  1  high while in HALT.
- `retired`  out  `RETIRE_W`  count of retired instructions.

## Operation
**State encodings:** FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, HALT = 7. Encodings 5 and 6 are unused and go to HALT.

**Supported opcodes (`instr[6:0]`):** OP 0110011, OP-IMM 0010011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011. Every other opcode is illegal.

Outputs are combinational from `state`, `instr` and `br_taken`. A strobe that is not listed for a state is 0, and a select that is not listed is 0.

**FETCH**
- `mem_req` = 1, `mem_addr_sel` = 0.
- While `mem_ready` = 0, stay in FETCH.
- On `mem_ready` = 1: assert `ir_we` in that cycle, then go to DECODE.

**DECODE**
- The register file reads rs1/rs2.
- Illegal opcode → HALT. Otherwise → EXEC.

**EXEC**
- Operand selects:
  - `alu_a_sel` = 1 for AUIPC and JAL; otherwise 0.
  - `alu_b_sel` = 1 for all opcodes except OP and BRANCH.
- BRANCH: assert `pc_we` = 1, with `pc_sel` = 1 if `br_taken` else 0. Increment `retired`. → FETCH.
- LOAD or STORE → MEM.
- All other opcodes → WB.

**MEM**
- `mem_req` = 1, `mem_addr_sel` = 1, `mem_we` = 1 if STORE.
- While `mem_ready` = 0, stay in MEM.
- On `mem_ready` = 1:
  - STORE: assert `pc_we` with `pc_sel` = 0, increment `retired`, → FETCH.
  - LOAD: → WB.

**WB**
- `reg_we` = 1 unless `instr[11:7]` = 0.
- `wb_sel` by opcode: LOAD = 1, JAL/JALR = 2, LUI = 3, otherwise 0.
- `pc_we` = 1 with `pc_sel` by opcode: JAL = 1, JALR = 2, otherwise 0.
- Increment `retired`. → FETCH.

**HALT**
- All strobes are 0 and `halted` = 1.
- No exit except reset.

**Counter and memory-request rules**
- `retired` increments by exactly 1 per retirement and wraps modulo 2^`RETIRE_W`.
- While `mem_req` is high and `mem_ready` is low, `mem_we` and `mem_addr_sel` stay constant.
- No new request is issued in the same cycle as a `mem_ready` completion.

## Timing
- **Reset:** asserting `rstn` low takes effect immediately, mid-instruction included.
  - `state` = FETCH, `retired` = 0, `halted` = 0.
  - `mem_req` is held at 0 while `rstn` is low.
- After reset release, the first cycle is FETCH with `mem_req` = 1.
- **Latency with zero-wait memory** (`mem_ready` high in the first request cycle), in cycles:
  - BRANCH: 3.
  - OP, OP-IMM, LUI, AUIPC, JAL, JALR, STORE: 4.
  - LOAD: 5.
- Each memory wait cycle adds exactly 1 cycle.
- `mem_ready` is ignored outside FETCH and MEM.
- `br_taken` is sampled only in EXEC.
- A PC write and a `retired` increment in the same cycle both take effect on the same edge.
- Illegal opcode: HALT is entered at the edge that ends DECODE, and `retired` is not incremented.

## Test plan
- **Reset and first fetch:** hold `rstn` low, then release with `mem_ready` = 1 and `instr` = 0x00500093 (addi x1,x0,5). Required:
  - state sequence 0, 1, 2, 4, 0;
  - in WB: `reg_we` = 1, `wb_sel` = 0, `pc_we` = 1, `pc_sel` = 0;
  - `retired` = 1.
- **Branch:** `instr` = 0x00000463 (beq x0,x0,8).
  - With `br_taken` = 1: EXEC has `pc_we` = 1, `pc_sel` = 1; 3 cycles; `retired` += 1.
  - With `br_taken` = 0: `pc_sel` = 0.
- **Load with wait states:** `instr` = 0x00002103 (lw x2,0(x0)), `mem_ready` low for 2 cycles in MEM. Required:
  - `mem_req` and `mem_addr_sel` = 1 held stable for 3 cycles;
  - then WB with `wb_sel` = 1, `reg_we` = 1;
  - 7 cycles total.
- **Store:** `instr` = 0x00102223 (sw x1,4(x0)). Required:
  - MEM has `mem_we` = 1;
  - `reg_we` never asserts;
  - `pc_we` with `pc_sel` = 0 on the completing cycle; 4 cycles.
- **Illegal opcode:** `instr` = 0x0000000B. Required:
  - HALT after DECODE; `halted` = 1;
  - `retired` unchanged;
  - `mem_req` stays 0 for 20 more cycles;
  - asserting `rstn` low recovers to FETCH.
- **Reset mid-MEM and counter wrap:**
  - Assert `rstn` low during MEM of an sw: `mem_req` drops immediately, `retired` = 0.
  - With `RETIRE_W` = 4: 16 retirements return `retired` to 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: fetch/decode/exec/mem/wb sequencer for a multi-cycle RV32I datapath.
// Drives datapath selects and strobes, handshakes the unified memory port, counts retirements.
`default_nettype none

module multicycle_ctrl #(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [31:0]         instr,
  input  logic                br_taken,
  input  logic                mem_ready,
  output logic                ir_we,
  output logic                pc_we,
  output logic [1:0]          pc_sel,
  output logic                mem_req,
  output logic                mem_we,
  output logic                mem_addr_sel,
  output logic                alu_a_sel,
  output logic                alu_b_sel,
  output logic                reg_we,
  output logic [1:0]          wb_sel,
  output logic [2:0]          state,
  output logic                halted,
  output logic [RETIRE_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [6:0] c_OPC_OP     = 7'b0110011;
  localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OPC_STORE  = 7'b0100011;

  state_t                state_q, state_d;
  logic [RETIRE_W-1:0]   retired_q;
  logic                  retire;
  logic                  req_raw;
  logic [6:0]            opc;
  logic                  legal;
  logic                  unused_instr_bits;

  assign opc               = instr[6:0];
  assign unused_instr_bits = ^instr[31:12];

  always_comb begin
    legal = 1'b0;
    case (opc)
      c_OPC_OP, c_OPC_OPIMM, c_OPC_LUI, c_OPC_AUIPC, c_OPC_JAL,
      c_OPC_JALR, c_OPC_BRANCH, c_OPC_LOAD, c_OPC_STORE: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) retired_q <= retired_q + 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    retire       = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 2'd0;
    req_raw      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    alu_a_sel    = 1'b0;
    alu_b_sel    = 1'b0;
    reg_we       = 1'b0;
    wb_sel       = 2'd0;
    halted       = 1'b0;

    case (state_q)
      S_FETCH: begin
        req_raw = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end
      end

      S_DECODE: state_d = legal ? S_EXEC : S_HALT;

      S_EXEC: begin
        alu_a_sel = (opc == c_OPC_AUIPC) || (opc == c_OPC_JAL);
        alu_b_sel = !((opc == c_OPC_OP) || (opc == c_OPC_BRANCH));
        if (opc == c_OPC_BRANCH) begin
          pc_we   = 1'b1;
          pc_sel  = {1'b0, br_taken};
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if ((opc == c_OPC_LOAD) || (opc == c_OPC_STORE)) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end

      // Address/direction are functions of state and instr only, so they hold through waits.
      S_MEM: begin
        req_raw      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (opc == c_OPC_STORE);
        if (mem_ready) begin
          if (opc == c_OPC_STORE) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end

      S_WB: begin
        reg_we = (instr[11:7] != 5'd0);
        case (opc)
          c_OPC_LOAD:             wb_sel = 2'd1;
          c_OPC_JAL, c_OPC_JALR:  wb_sel = 2'd2;
          c_OPC_LUI:              wb_sel = 2'd3;
          default:                wb_sel = 2'd0;
        endcase
        pc_we = 1'b1;
        case (opc)
          c_OPC_JAL:  pc_sel = 2'd1;
          c_OPC_JALR: pc_sel = 2'd2;
          default:    pc_sel = 2'd0;
        endcase
        retire  = 1'b1;
        state_d = S_FETCH;
      end

      S_HALT: halted = 1'b1;

      default: state_d = S_HALT;
    endcase
  end

  // Reset forces the request low combinationally, not just at the next edge.
  assign mem_req = req_raw & rstn;
  assign state   = state_q;
  assign retired = retired_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed instruction traces checked cycle-by-cycle against a
// per-instruction trace model, plus hand-computed retirement/length literals.
`default_nettype none

module tb_multicycle_ctrl;

  localparam int RW   = 4;
  localparam int MASK = (1 << RW) - 1;

  logic          clk = 1'b0;
  logic          rstn;
  logic [31:0]   instr;
  logic          br_taken;
  logic          mem_ready;
  logic          ir_we, pc_we, mem_req, mem_we, mem_addr_sel;
  logic          alu_a_sel, alu_b_sel, reg_we, halted;
  logic [1:0]    pc_sel, wb_sel;
  logic [2:0]    state;
  logic [RW-1:0] retired;

  multicycle_ctrl #(.RETIRE_W(RW)) dut (
    .clk(clk), .rstn(rstn), .instr(instr), .br_taken(br_taken), .mem_ready(mem_ready),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .reg_we(reg_we), .wb_sel(wb_sel), .state(state), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       rdy;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       mem_req;
    logic       mem_we;
    logic       mas;
    logic       aa;
    logic       ab;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic       halted;
    logic       retire;
  } cyc_t;

  cyc_t  plan[$];
  cyc_t  e;
  int    e_ret;
  logic  exp_valid = 1'b0;
  logic  br_cur;
  int    cnt;
  int    n_vec = 0;
  int    n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_valid) begin
      chk("state",        {29'd0, state},        {29'd0, e.st});
      chk("ir_we",        {31'd0, ir_we},        {31'd0, e.ir_we});
      chk("pc_we",        {31'd0, pc_we},        {31'd0, e.pc_we});
      chk("pc_sel",       {30'd0, pc_sel},       {30'd0, e.pc_sel});
      chk("mem_req",      {31'd0, mem_req},      {31'd0, e.mem_req});
      chk("mem_we",       {31'd0, mem_we},       {31'd0, e.mem_we});
      chk("mem_addr_sel", {31'd0, mem_addr_sel}, {31'd0, e.mas});
      chk("alu_a_sel",    {31'd0, alu_a_sel},    {31'd0, e.aa});
      chk("alu_b_sel",    {31'd0, alu_b_sel},    {31'd0, e.ab});
      chk("reg_we",       {31'd0, reg_we},       {31'd0, e.reg_we});
      chk("wb_sel",       {30'd0, wb_sel},       {30'd0, e.wb_sel});
      chk("halted",       {31'd0, halted},       {31'd0, e.halted});
      chk("retired",      {28'd0, retired},      e_ret);
    end
  end

  function automatic cyc_t blank(input logic [2:0] s);
    cyc_t r;
    r     = '0;
    r.st  = s;
    r.rdy = 1'b1;
    return r;
  endfunction

  // Expected trace of one instruction: fw/mw are wait cycles on the fetch and data access.
  task automatic build(input logic [31:0] ins, input logic br, input int fw, input int mw);
    logic [6:0] op;
    logic       ld, st, legal;
    cyc_t       r;
    op    = ins[6:0];
    ld    = (op == 7'b0000011);
    st    = (op == 7'b0100011);
    legal = (op inside {7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111,
                        7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011});
    plan.delete();
    for (int i = 0; i <= fw; i++) begin
      r = blank(3'd0); r.mem_req = 1'b1; r.rdy = (i == fw); r.ir_we = (i == fw);
      plan.push_back(r);
    end
    plan.push_back(blank(3'd1));
    if (!legal) begin
      for (int i = 0; i < 20; i++) begin
        r = blank(3'd7); r.halted = 1'b1; plan.push_back(r);
      end
      return;
    end
    r = blank(3'd2);
    r.aa = (op == 7'b0010111) || (op == 7'b1101111);
    r.ab = !(op == 7'b0110011 || op == 7'b1100011);
    if (op == 7'b1100011) begin
      r.pc_we = 1'b1; r.pc_sel = br ? 2'd1 : 2'd0; r.retire = 1'b1;
      plan.push_back(r);
      return;
    end
    plan.push_back(r);
    if (ld || st) begin
      for (int i = 0; i <= mw; i++) begin
        r = blank(3'd3); r.mem_req = 1'b1; r.mas = 1'b1; r.mem_we = st; r.rdy = (i == mw);
        if (st && i == mw) begin r.pc_we = 1'b1; r.retire = 1'b1; end
        plan.push_back(r);
      end
      if (st) return;
    end
    r = blank(3'd4);
    r.reg_we = (ins[11:7] != 5'd0);
    r.wb_sel = ld ? 2'd1 : (op == 7'b1101111 || op == 7'b1100111) ? 2'd2 :
               (op == 7'b0110111) ? 2'd3 : 2'd0;
    r.pc_we  = 1'b1;
    r.pc_sel = (op == 7'b1101111) ? 2'd1 : (op == 7'b1100111) ? 2'd2 : 2'd0;
    r.retire = 1'b1;
    plan.push_back(r);
  endtask

  // Called at posedge+1; each record covers the cycle up to the next rising edge.
  task automatic run_plan(input int limit);
    for (int i = 0; i < plan.size() && (limit < 0 || i < limit); i++) begin
      mem_ready = plan[i].rdy;
      br_taken  = (plan[i].st == 3'd2) ? br_cur : ~br_cur;
      e         = plan[i];
      e_ret     = cnt;
      exp_valid = 1'b1;
      @(posedge clk);
      #1;
      if (plan[i].retire) cnt = (cnt + 1) & MASK;
    end
    exp_valid = 1'b0;
  endtask

  task automatic do_instr(input logic [31:0] ins, input logic br, input int fw, input int mw,
                          input int exp_len, input int exp_st, input int exp_ret);
    instr  = ins;
    br_cur = br;
    build(ins, br, fw, mw);
    chk("trace_len", plan.size(), exp_len);
    run_plan(-1);
    chk("state_after",   {29'd0, state},   exp_st);
    chk("retired_after", {28'd0, retired}, exp_ret);
  endtask

  task automatic check_in_reset();
    chk("rst_state",   {29'd0, state},   0);
    chk("rst_mem_req", {31'd0, mem_req}, 0);
    chk("rst_retired", {28'd0, retired}, 0);
    chk("rst_halted",  {31'd0, halted},  0);
  endtask

  initial begin
    rstn = 1'b0; instr = 32'h0; br_taken = 1'b0; mem_ready = 1'b1; cnt = 0;
    repeat (2) @(posedge clk);
    #3;
    check_in_reset();
    @(posedge clk); #1;
    rstn = 1'b1;

    do_instr(32'h00500093, 1'b0, 0, 0, 4, 0, 1);   // addi x1,x0,5
    do_instr(32'h00000463, 1'b1, 0, 0, 3, 0, 2);   // beq taken
    do_instr(32'h00000463, 1'b0, 0, 0, 3, 0, 3);   // beq not taken
    do_instr(32'h00002103, 1'b0, 0, 2, 7, 0, 4);   // lw, two wait cycles
    do_instr(32'h00102223, 1'b0, 0, 0, 4, 0, 5);   // sw
    do_instr(32'h008000EF, 1'b1, 0, 0, 4, 0, 6);   // jal x1,8
    do_instr(32'h000100E7, 1'b0, 2, 0, 6, 0, 7);   // jalr, two fetch waits
    do_instr(32'h000011B7, 1'b0, 0, 0, 4, 0, 8);   // lui x3,1
    do_instr(32'h00000217, 1'b0, 0, 0, 4, 0, 9);   // auipc x4,0
    do_instr(32'h00208033, 1'b1, 0, 0, 4, 0, 10);  // add x0,x1,x2

    // Reset during the data access of a store.
    instr = 32'h00102223; br_cur = 1'b0;
    build(32'h00102223, 1'b0, 0, 5);
    run_plan(5);
    chk("pre_rst_mem_req", {31'd0, mem_req}, 1);
    chk("pre_rst_state",   {29'd0, state},   3);
    #2;
    rstn = 1'b0;
    #1;
    check_in_reset();
    cnt = 0;
    @(posedge clk); #1;
    rstn = 1'b1;

    for (int i = 1; i <= 16; i++)
      do_instr(32'h00500093, 1'b0, 0, 0, 4, 0, i % 16);

    do_instr(32'h00500093, 1'b0, 0, 0, 4, 0, 1);
    do_instr(32'h0000000B, 1'b0, 0, 0, 22, 7, 1);  // illegal opcode
    chk("halt_flag", {31'd0, halted}, 1);
    #2;
    rstn = 1'b0;
    #1;
    check_in_reset();
    cnt = 0;
    @(posedge clk); #1;
    rstn = 1'b1;
    do_instr(32'h00500093, 1'b0, 1, 0, 5, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
